// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the iterative multiply/divide units.
// Holds the selected unit's run strobe for ITER_COUNT cycles, then issues the
// HI/LO write (WB) or, on a zero divisor, a one-cycle div_zero exception (EXC).
// Optional feature: define MULDIV_ABORT_EN to add the `abort` flush input.
module muldiv_seq #(
    parameter int ITER_COUNT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_req,
    input  logic        div_req,
    input  logic [31:0] divisor,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic        hilo_src,
    output logic        hilo_write,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WB,
        S_EXC
    } state_t;

    localparam logic [6:0] LAST_ITER = 7'(ITER_COUNT - 1);

    state_t     state, state_nxt;
    logic [6:0] cnt, cnt_nxt;
    logic       op, op_nxt;
    logic       flush;

`ifdef MULDIV_ABORT_EN
    assign flush = abort;
`else
    assign flush = 1'b0;
`endif

    // State, iteration counter and op bit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
        end
    end

    // Next-state logic: request acceptance, iteration count, write-back/exception exit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op;
        case (state)
            S_IDLE: begin
                if (mult_req) begin
                    op_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end else if (div_req) begin
                    if (divisor != '0) begin
                        op_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_EXC;
                    end
                end
            end
            S_RUN: begin
                cnt_nxt = cnt + 7'd1;
                if (cnt == LAST_ITER) state_nxt = S_WB;
            end
            S_WB:  state_nxt = S_IDLE;
            S_EXC: state_nxt = S_IDLE;
        endcase
        // Flush overrides everything, including a request seen in IDLE
        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = cnt;
            op_nxt    = op;
        end
    end

    // Outputs decoded from registered state and op bit only
    always_comb begin
        mult_ctrl  = (state == S_RUN) && !op;
        div_ctrl   = (state == S_RUN) && op;
        hilo_src   = op;
        hilo_write = (state == S_WB);
        done       = (state == S_WB);
        div_zero   = (state == S_EXC);
        busy       = (state != S_IDLE);
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized plus directed bench for muldiv_seq.
// The reference model tracks the active operation and its age (edges since
// acceptance) and derives every expected output from the timing rules.
module tb_muldiv_seq;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_req = 1'b0;
    logic        div_req = 1'b0;
    logic [31:0] divisor = '0;
    logic        abort = 1'b0;
    logic        mult_ctrl, div_ctrl, hilo_src, hilo_write, busy, done, div_zero;

    int n_vec = 0;
    int n_err = 0;

    // model: 0 = idle, 1 = multiply, 2 = divide, 3 = divide-by-zero exception
    int act = 0;
    int age = 0;
    bit op_m = 1'b0;

    always #5 clk = ~clk;

    muldiv_seq #(.ITER_COUNT(ITER)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_req   (mult_req),
        .div_req    (div_req),
        .divisor    (divisor),
`ifdef MULDIV_ABORT_EN
        .abort      (abort),
`endif
        .mult_ctrl  (mult_ctrl),
        .div_ctrl   (div_ctrl),
        .hilo_src   (hilo_src),
        .hilo_write (hilo_write),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%b expected=%b", tag, $time, got[6:0], exp[6:0]);
        end
    endtask

    function automatic logic [6:0] expected_outs();
        logic run, wb;
        run = (act == 1 || act == 2) && age < ITER;
        wb  = (act == 1 || act == 2) && age == ITER;
        return {run && act == 1, run && act == 2, op_m, wb, act != 0, wb, act == 3};
    endfunction

    function automatic logic [6:0] dut_outs();
        return {mult_ctrl, div_ctrl, hilo_src, hilo_write, busy, done, div_zero};
    endfunction

    // Advance the model across one rising edge with the inputs that were applied
    task automatic model_edge(input bit m, input bit d, input logic [31:0] dv, input bit ab);
        if (ab) begin
            act = 0;
        end else if (act == 0) begin
            if (m) begin
                act = 1; op_m = 1'b0; age = 0;
            end else if (d) begin
                if (dv != 0) begin
                    act = 2; op_m = 1'b1;
                end else begin
                    act = 3;
                end
                age = 0;
            end
        end else begin
            age++;
            if (act == 3 || age > ITER) act = 0;
        end
    endtask

    // One cycle: check outputs, apply inputs at negedge, advance model at posedge
    task automatic step(input bit m, input bit d, input logic [31:0] dv, input bit ab);
        @(negedge clk);
        check_eq("outs", 32'(dut_outs()), 32'(expected_outs()));
        mult_req = m;
        div_req  = d;
        divisor  = dv;
`ifdef MULDIV_ABORT_EN
        abort    = ab;
`else
        abort    = 1'b0;
`endif
        @(posedge clk);
        model_edge(m, d, dv, abort);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd5, 1'b0);
    endtask

    // Asynchronous reset pulse launched between edges; outputs must clear at once
    task automatic pulse_reset();
        @(negedge clk);
        mult_req = 1'b0; div_req = 1'b0; abort = 1'b0;
        reset = 1'b0;
        #1;
        act = 0; age = 0; op_m = 1'b0;
        check_eq("reset_outs", 32'(dut_outs()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("in_reset", 32'(dut_outs()), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        pulse_reset();

        // multiply
        step(1'b1, 1'b0, 32'd0, 1'b0);
        idle(ITER + 4);

        // divide by 7, divisor changed to 0 mid-run
        step(1'b0, 1'b1, 32'd7, 1'b0);
        idle(10);
        for (int i = 0; i < ITER; i++) step(1'b0, 1'b0, 32'd0, 1'b0);

        // divide by zero
        step(1'b0, 1'b1, 32'd0, 1'b0);
        idle(3);

        // simultaneous requests, ignored div mid-run, back-to-back multiply
        step(1'b1, 1'b1, 32'd9, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 32'd3, 1'b0);
        idle(ITER + 1 - 6);
        step(1'b1, 1'b0, 32'd3, 1'b0);
        idle(ITER + 3);

        // reset at iteration 10
        step(1'b1, 1'b0, 32'd0, 1'b0);
        idle(10);
        pulse_reset();
        idle(ITER + 4);

`ifdef MULDIV_ABORT_EN
        // abort at iteration 10
        step(1'b0, 1'b1, 32'd11, 1'b0);
        idle(9);
        step(1'b0, 1'b0, 32'd11, 1'b1);
        idle(ITER + 4);
        // abort in IDLE beats a request
        step(1'b1, 1'b0, 32'd0, 1'b1);
        idle(3);
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit m, d, ab;
            logic [31:0] dv;
            m  = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 59) == 0);
            dv = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 599) == 0) pulse_reset();
            else step(m, d, dv, ab);
        end
        idle(ITER + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
